// File: rtl/draw_processor_pkg.sv
// Shared constants for the drawing pipeline: coordinate/colour widths,
// screen size, instruction opcodes and instruction field positions.
package draw_processor_pkg;

    localparam int X_COORD_WIDTH     = 8;
    localparam int Y_COORD_WIDTH     = 7;
    localparam int COLOUR_WIDTH      = 3;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int RESULT_WIDTH      = 32;
    localparam int SCREEN_WIDTH      = 160;
    localparam int SCREEN_HEIGHT     = 120;

    // Opcodes carried in instruction[31:28].
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PLOT  = 4'd1;
    localparam logic [3:0] OP_CLEAR = 4'd2;
    localparam logic [3:0] OP_HSPAN = 4'd3;

    // Instruction field bit positions.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int LENGTH_MSB = 27;
    localparam int LENGTH_LSB = 19;
    localparam int PLOT_BIT   = 18;
    localparam int COLOUR_MSB = 17;
    localparam int COLOUR_LSB = 15;
    localparam int Y_MSB      = 14;
    localparam int Y_LSB      = 8;
    localparam int X_MSB      = 7;
    localparam int X_LSB      = 0;
    localparam int LENGTH_WIDTH = LENGTH_MSB - LENGTH_LSB + 1;

    // Last valid coordinates, sized to the coordinate buses.
    localparam logic [X_COORD_WIDTH-1:0] X_LAST = X_COORD_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [Y_COORD_WIDTH-1:0] Y_LAST = Y_COORD_WIDTH'(SCREEN_HEIGHT - 1);

    localparam logic [RESULT_WIDTH-1:0] CLEAR_PIXELS   = RESULT_WIDTH'(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam logic [RESULT_WIDTH-1:0] RESULT_ILLEGAL = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PIXEL,
        ST_SCAN
    } state_t;

endpackage

// File: rtl/draw_processor_pixel_scan.sv
// pixel_scan: loadable raster counter shared by CLEAR and HSPAN.
//   load/load_x/load_y/load_end_x/load_wrap : capture start point, row end
//                                             and whether rows wrap to y+1
//   advance                                 : step to the next pixel
//   x, y                                    : current pixel (registered)
//   last                                    : current pixel is the final one
module pixel_scan
    import draw_processor_pkg::*;
(
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     load,
    input  logic                     advance,
    input  logic [X_COORD_WIDTH-1:0] load_x,
    input  logic [Y_COORD_WIDTH-1:0] load_y,
    input  logic [X_COORD_WIDTH-1:0] load_end_x,
    input  logic                     load_wrap,
    output logic [X_COORD_WIDTH-1:0] x,
    output logic [Y_COORD_WIDTH-1:0] y,
    output logic                     last
);

    logic [X_COORD_WIDTH-1:0] end_x;
    logic                     wrap;

    // A wrapping scan (full-screen clear) ends on the bottom row only.
    assign last = (x == end_x) && (!wrap || (y == Y_LAST));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x     <= '0;
            y     <= '0;
            end_x <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            x     <= load_x;
            y     <= load_y;
            end_x <= load_end_x;
            wrap  <= load_wrap;
        end else if (advance) begin
            // Reaching end_x without being last only happens when wrapping.
            if (x == end_x) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_processor.sv
// draw_processor: executes one drawing instruction at a time and turns it
// into single-cycle pixel writes on the VGA adapter write port.
//   clock, resetn          : clock, asynchronous active-low reset
//   start, instruction     : launch request (rising level) and instruction
//   finished, result       : idle flag and completion word of last instruction
//   vga_x/vga_y/vga_colour : pixel written while vga_plot=1
//   vga_plot               : write strobe, one pixel per cycle
module draw_processor
    import draw_processor_pkg::*;
(
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         finished,
    output logic [RESULT_WIDTH-1:0]      result,
    output logic [X_COORD_WIDTH-1:0]     vga_x,
    output logic [Y_COORD_WIDTH-1:0]     vga_y,
    output logic [COLOUR_WIDTH-1:0]      vga_colour,
    output logic                         vga_plot
);

    state_t state;
    logic   start_q;
    logic [RESULT_WIDTH-1:0] pending_result;

    // Instruction fields.
    logic [3:0]               op;
    logic [LENGTH_WIDTH-1:0]  i_len;
    logic                     i_plot;
    logic [COLOUR_WIDTH-1:0]  i_colour;
    logic [Y_COORD_WIDTH-1:0] i_y;
    logic [X_COORD_WIDTH-1:0] i_x;

    assign op       = instruction[OPCODE_MSB:OPCODE_LSB];
    assign i_len    = instruction[LENGTH_MSB:LENGTH_LSB];
    assign i_plot   = instruction[PLOT_BIT];
    assign i_colour = instruction[COLOUR_MSB:COLOUR_LSB];
    assign i_y      = instruction[Y_MSB:Y_LSB];
    assign i_x      = instruction[X_MSB:X_LSB];

    logic launch;
    assign launch = (state == ST_IDLE) && start && !start_q;

    // Decode of the instruction presented at the launch edge.
    logic                     on_screen;
    logic [9:0]               span_end;
    logic [9:0]               span_stop;
    logic [9:0]               span_count;
    state_t                   dec_state;
    logic                     dec_plot;
    logic [X_COORD_WIDTH-1:0] dec_x;
    logic [Y_COORD_WIDTH-1:0] dec_y;
    logic [X_COORD_WIDTH-1:0] dec_end_x;
    logic                     dec_wrap;
    logic [RESULT_WIDTH-1:0]  dec_result;

    assign on_screen  = (i_x <= X_LAST) && (i_y <= Y_LAST);
    // Exclusive end kept wide so a long span clips instead of wrapping to x=0.
    assign span_end   = {2'b00, i_x} + {1'b0, i_len};
    assign span_stop  = (span_end > 10'(SCREEN_WIDTH)) ? 10'(SCREEN_WIDTH) : span_end;
    assign span_count = span_stop - {2'b00, i_x};

    // NOTE: every always_comb output is given a default first so no
    // opcode path can leave a signal unassigned and infer a latch.
    always_comb begin
        dec_state  = ST_PIXEL;
        dec_plot   = 1'b0;
        dec_x      = i_x;
        dec_y      = i_y;
        dec_end_x  = i_x;
        dec_wrap   = 1'b0;
        dec_result = '0;
        case (op)
            OP_NOP: ;
            OP_PLOT: begin
                dec_plot   = i_plot && on_screen;
                dec_result = RESULT_WIDTH'(dec_plot);
            end
            OP_CLEAR: begin
                dec_state  = ST_SCAN;
                dec_plot   = 1'b1;
                dec_x      = '0;
                dec_y      = '0;
                dec_end_x  = X_LAST;
                dec_wrap   = 1'b1;
                dec_result = CLEAR_PIXELS;
            end
            OP_HSPAN: begin
                // An empty span behaves like a NOP: one cycle busy, no writes.
                if (on_screen && (i_len != '0)) begin
                    dec_state  = ST_SCAN;
                    dec_plot   = 1'b1;
                    dec_end_x  = X_COORD_WIDTH'(span_stop - 10'd1);
                    dec_result = RESULT_WIDTH'(span_count);
                end
            end
            default: dec_result = RESULT_ILLEGAL;
        endcase
    end

    logic scan_last;
    logic scan_advance;
    assign scan_advance = (state == ST_SCAN) && !scan_last;

    // The counter registers drive the VGA coordinate outputs directly.
    pixel_scan u_pixel_scan (
        .clock      (clock),
        .resetn     (resetn),
        .load       (launch),
        .advance    (scan_advance),
        .load_x     (dec_x),
        .load_y     (dec_y),
        .load_end_x (dec_end_x),
        .load_wrap  (dec_wrap),
        .x          (vga_x),
        .y          (vga_y),
        .last       (scan_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            start_q        <= 1'b0;
            finished       <= 1'b1;
            result         <= '0;
            pending_result <= '0;
            vga_colour     <= '0;
            vga_plot       <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state          <= dec_state;
                        finished       <= 1'b0;
                        vga_plot       <= dec_plot;
                        vga_colour     <= i_colour;
                        pending_result <= dec_result;
                    end
                end
                ST_PIXEL: begin
                    state    <= ST_IDLE;
                    finished <= 1'b1;
                    vga_plot <= 1'b0;
                    result   <= pending_result;
                end
                ST_SCAN: begin
                    if (scan_last) begin
                        state    <= ST_IDLE;
                        finished <= 1'b1;
                        vga_plot <= 1'b0;
                        result   <= pending_result;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_processor.sv
// Scoreboard bench for draw_processor: stimulus pushes expected pixels and
// completion words; a negedge monitor pops and compares them.
module tb_draw_processor;
    import draw_processor_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] instruction = '0;
    logic        finished;
    logic [31:0] result;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    draw_processor dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .instruction (instruction),
        .finished    (finished),
        .result      (result),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    always #5 clock = ~clock;

    logic [17:0] pix_q[$];   // {x, y, colour}
    logic [31:0] res_q[$];
    int          low_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [8:0] len,
                                       input logic pl, input logic [2:0] col,
                                       input logic [6:0] y, input logic [7:0] x);
        return {op, len, pl, col, y, x};
    endfunction

    function automatic logic [17:0] px(input int x, input int y, input logic [2:0] c);
        return {8'(x), 7'(y), c};
    endfunction

    // Monitor: pixel strobes and completions, sampled on the falling edge.
    logic prev_fin = 1'b1;
    int   low_cnt  = 0;
    always @(negedge clock) begin
        if (!resetn) begin
            prev_fin = 1'b1;
            low_cnt  = 0;
            pix_q.delete();
            res_q.delete();
            low_q.delete();
        end else begin
            if (vga_plot) begin
                if (pix_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL strobe: unexpected write at (%0d,%0d) colour %0d", vga_x, vga_y, vga_colour);
                end else begin
                    check("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(pix_q.pop_front()));
                end
            end
            if (!finished) low_cnt++;
            if (finished && !prev_fin) begin
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL completion: unexpected, result %0h", result);
                end else begin
                    check("result", result, res_q.pop_front());
                    check("busy_cycles", 32'(low_cnt), 32'(low_q.pop_front()));
                end
                low_cnt = 0;
            end
            prev_fin = finished;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_done(input logic [31:0] res, input int low);
        res_q.push_back(res);
        low_q.push_back(low);
    endtask

    task automatic send(input logic [31:0] instr, input int hold);
        instruction = instr;
        start = 1'b1;
        repeat (hold) tick();
        start = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int limit, input string name);
        int i = 0;
        while (!finished && i < limit) begin
            tick();
            i++;
        end
        check(name, 32'(finished), 32'd1);
        tick();
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        check("rst_finished", 32'(finished), 32'd1);
        check("rst_plot", 32'(vga_plot), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        resetn = 1'b1;
        tick();

        // PLOT inside the screen.
        pix_q.push_back(px(5, 7, 3'b010));
        expect_done(32'd1, 1);
        send(mk(OP_PLOT, 9'd0, 1'b1, 3'b010, 7'd7, 8'd5), 1);
        wait_idle(10, "idle_plot");

        // PLOT with plot=0, then off-screen x.
        expect_done(32'd0, 1);
        send(mk(OP_PLOT, 9'd0, 1'b0, 3'b010, 7'd7, 8'd5), 1);
        wait_idle(10, "idle_plot0");
        expect_done(32'd0, 1);
        send(mk(OP_PLOT, 9'd0, 1'b1, 3'b010, 7'd7, 8'd200), 1);
        wait_idle(10, "idle_plotx");

        // Start held high for 4 cycles gives one strobe; re-raise gives another.
        pix_q.push_back(px(20, 30, 3'b100));
        expect_done(32'd1, 1);
        send(mk(OP_PLOT, 9'd0, 1'b1, 3'b100, 7'd30, 8'd20), 4);
        wait_idle(10, "idle_held");
        pix_q.push_back(px(20, 30, 3'b100));
        expect_done(32'd1, 1);
        send(mk(OP_PLOT, 9'd0, 1'b1, 3'b100, 7'd30, 8'd20), 1);
        wait_idle(10, "idle_reraise");

        // NOP and an illegal opcode.
        expect_done(32'd0, 1);
        send(mk(OP_NOP, 9'd5, 1'b1, 3'b111, 7'd1, 8'd1), 1);
        wait_idle(10, "idle_nop");
        expect_done(32'hFFFF_FFFF, 1);
        send(mk(4'd9, 9'd5, 1'b1, 3'b111, 7'd1, 8'd1), 1);
        wait_idle(10, "idle_illegal");

        // HSPAN clipped at the right edge, empty span, and bottom-row span.
        for (int x = 150; x < 160; x++) pix_q.push_back(px(x, 10, 3'b101));
        expect_done(32'd10, 10);
        send(mk(OP_HSPAN, 9'd20, 1'b1, 3'b101, 7'd10, 8'd150), 1);
        wait_idle(50, "idle_hspan");
        expect_done(32'd0, 1);
        send(mk(OP_HSPAN, 9'd0, 1'b1, 3'b101, 7'd10, 8'd150), 1);
        wait_idle(10, "idle_hspan0");
        for (int x = 0; x < 3; x++) pix_q.push_back(px(x, 119, 3'b001));
        expect_done(32'd3, 3);
        send(mk(OP_HSPAN, 9'd3, 1'b0, 3'b001, 7'd119, 8'd0), 1);
        wait_idle(50, "idle_hspan3");

        // Full CLEAR with start pulses ignored mid-scan.
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++) pix_q.push_back(px(x, y, 3'b111));
        expect_done(32'd19200, 19200);
        send(mk(OP_CLEAR, 9'd0, 1'b0, 3'b111, 7'd50, 8'd50), 1);
        instruction = mk(OP_PLOT, 9'd0, 1'b1, 3'b000, 7'd0, 8'd0);
        repeat (3) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
        end
        wait_idle(20000, "idle_clear");

        // Reset mid-CLEAR aborts at once; the next PLOT works.
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++) pix_q.push_back(px(x, y, 3'b011));
        expect_done(32'd19200, 19200);
        send(mk(OP_CLEAR, 9'd0, 1'b1, 3'b011, 7'd0, 8'd0), 1);
        repeat (50) tick();
        resetn = 1'b0;
        #1;
        check("abort_finished", 32'(finished), 32'd1);
        check("abort_plot", 32'(vga_plot), 32'd0);
        check("abort_result", result, 32'd0);
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        pix_q.push_back(px(159, 119, 3'b110));
        expect_done(32'd1, 1);
        send(mk(OP_PLOT, 9'd0, 1'b1, 3'b110, 7'd119, 8'd159), 1);
        wait_idle(10, "idle_after_reset");

        repeat (3) tick();
        check("pixels_left", 32'(pix_q.size()), 32'd0);
        check("results_left", 32'(res_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/draw_processor.md
# draw_processor

Instruction executor that sits directly downstream of the drawing clients (ant, background and food renderers). It accepts one instruction at a time over the `start`/`finished` handshake, turns it into single-cycle pixel writes on the VGA adapter write port, and returns a result word. Multi-pixel operations (screen clear, horizontal span) are sequenced internally so clients issue one instruction instead of one per pixel.

## Interface
- Parameters: none; all widths and screen size come from the shared constants (`X_COORD_WIDTH`=8, `Y_COORD_WIDTH`=7, `COLOUR_WIDTH`=3, `INSTRUCTION_WIDTH`=32, `RESULT_WIDTH`=32, `SCREEN_WIDTH`=160, `SCREEN_HEIGHT`=120).
- Clock and reset: one clock; reset is asynchronous and active-low.
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; a rising level, with `finished`=1, launches `instruction`
- instruction  in  32  [31:28] opcode, [27:19] length, [18] plot, [17:15] colour, [14:8] y, [7:0] x
- finished  out  1  1 = idle and `result` valid
- result  out  32  completion word of last instruction
- vga_x  out  8  pixel x to adapter
- vga_y  out  7  pixel y to adapter
- vga_colour  out  3  pixel colour to adapter
- vga_plot  out  1  write strobe, one pixel per cycle high

## Operation
- States: IDLE, PIXEL, SCAN. Reset forces IDLE; every output resets to 0 except `finished`=1.
- Accept: in IDLE, `start`=1 while the registered previous `start` was 0 → latch the instruction, clear `finished`. A level held high never re-launches; the client must drop `start` for at least one cycle. `start` in PIXEL/SCAN is ignored.
- Opcode 0 NOP: no writes; `result`=0.
- Opcode 1 PLOT → PIXEL: one write at (x,y) if plot=1 and x<160 and y<120; `result`=1, else 0.
- Opcode 2 CLEAR → SCAN: writes all 19200 pixels in raster order (x fastest, x=0..159, then y+1) with the latched colour; plot bit ignored; `result`=19200.
- Opcode 3 HSPAN → SCAN: writes (x..x+length−1, y), clipped at x=159. Compute the end as a 9-bit+ sum; no wrap to x=0. length=0, y≥120 or x≥160 → no writes. `result` = number of pixels written.
- Opcodes 4–15: no writes; `result`=32'hFFFF_FFFF.
- `result` is updated on the same edge that sets `finished`, and holds until the next completion.
- Reset mid-SCAN aborts immediately: `vga_plot` drops asynchronously, IDLE, `result`=0.

## Timing
- All outputs are registered.
- Accept edge E: `finished` low from E.
- PLOT: `vga_plot` high for cycle E..E+1; `finished`=1 with `result` at E+1.
- NOP and illegal opcodes: `finished` low exactly one cycle.
- SCAN of N pixels: `vga_plot` high for N consecutive cycles starting at E, with new coordinates every cycle. `finished` rises on the edge ending the last write (N cycles low; N=0 → 1 cycle low).
- `vga_x`/`vga_y`/`vga_colour` are valid whenever `vga_plot`=1 and are don't-care otherwise.

## Structure
- Shared constants header: add opcode constants (`OP_NOP`, `OP_PLOT`, `OP_CLEAR`, `OP_HSPAN`) and instruction field bit positions beside the existing widths and screen size.
- One sub-module: `pixel_scan`, a loadable raster counter (start x/y, end x, row-wrap enable) with a `last` flag. It serves both CLEAR and HSPAN.

## Test plan
- Reset: `resetn` low mid-CLEAR → `finished`=1, `vga_plot`=0, `result`=0 immediately; the next PLOT works normally.
- PLOT (x=5, y=7, colour=3'b010, plot=1) → one strobe at (5,7,010), `finished` low one cycle, `result`=1. Same instruction with plot=0, or x=200 → no strobe, `result`=0.
- Held start: `start` held high for 4 cycles on PLOT → exactly one strobe. Drop and re-raise `start` → second strobe.
- CLEAR colour 3'b111 → 19200 consecutive strobes, first (0,0), last (159,119), row wrap after x=159. `result`=19200; `start` pulses mid-scan are ignored.
- HSPAN x=150, y=10, length=20 → strobes x=150..159 only, `result`=10. length=0 → no strobes, `result`=0.
- Opcode 4'd9 → no strobe, `finished` low one cycle, `result`=32'hFFFF_FFFF.
